// File: rtl/alu_pkg.sv
// Shared types and constants for the arithmetic blocks.
package alu_pkg;

    localparam int unsigned DivWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
    import alu_pkg::*;
#(
    parameter int unsigned N = DivWidth
) (
    input  logic [N:0]   i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_rem,
    output logic         o_qbit
);

    logic [N+1:0] w_shift;
    logic [N+1:0] w_diff;

    // One extra bit so the sign of the trial subtraction is never lost.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_divisor};
    assign o_qbit  = ~w_diff[N+1];
    assign o_rem   = o_qbit ? w_diff[N:0] : w_shift[N:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock, MSB first.
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned N = DivWidth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int unsigned CntW = $clog2(N + 1);

    div_state_e r_state;
    div_state_e w_state_next;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N:0]      r_rem;
    logic [CntW-1:0] r_cnt;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_r;
    logic            r_div_zero;

    logic [N:0] w_rem;
    logic       w_qbit;
    logic       w_last;

    div_step #(
        .N(N)
    ) u_div_step (
        .i_rem    (r_rem),
        .i_bit    (r_a[N-1]),
        .i_divisor(r_b),
        .o_rem    (w_rem),
        .o_qbit   (w_qbit)
    );

    assign w_last = (r_cnt == CntW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = (b == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        busy = (r_state != StIdle);
        done = (r_state == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (b == '0) begin
                            r_q        <= '0;
                            r_r        <= '0;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                StCalc: begin
                    r_a   <= r_a << 1;
                    r_rem <= w_rem;
                    r_q   <= {r_q[N-2:0], w_qbit};
                    r_cnt <= r_cnt + CntW'(1);
                    // Remainder is published only once the final step has settled.
                    if (w_last) begin
                        r_r <= w_rem[N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q        = r_q;
    assign r        = r_r;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases, reset abort and an exhaustive 4-bit sweep.
module tb_seq_divider;

    localparam int unsigned N = 4;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int unsigned  lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic         div_zero;

    exp_t sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    seq_divider #(
        .N(N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .q       (q),
        .r       (r),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        n_total++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // With noise set, start stays high with random operands until done has passed.
    task automatic run_div(input logic [N-1:0] ta, input logic [N-1:0] tb, input bit noise);
        exp_t        e;
        int unsigned edges;
        bit          seen;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        e.q   = (tb == '0) ? '0 : ta / tb;
        e.r   = (tb == '0) ? '0 : ta % tb;
        e.dz  = (tb == '0);
        e.lat = (tb == '0) ? 1 : N + 1;
        sb.push_back(e);
        @(posedge clk);
        edges = 1;
        seen  = 1'b0;
        while (edges <= 20) begin
            @(negedge clk);
            if (!noise) start = 1'b0;
            a = N'($urandom);
            b = N'($urandom);
            if (done) begin
                seen = 1'b1;
                break;
            end
            check_eq("busy_in_calc", 32'(busy), 1);
            @(posedge clk);
            edges++;
        end
        check_eq("done_seen", 32'(seen), 1);
        e = sb.pop_front();
        check_eq("latency", edges, e.lat);
        check_eq("q", 32'(q), 32'(e.q));
        check_eq("r", 32'(r), 32'(e.r));
        check_eq("div_zero", 32'(div_zero), 32'(e.dz));
        check_eq("busy_in_done", 32'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse_end", 32'(done), 0);
        check_eq("busy_after", 32'(busy), 0);
        check_eq("q_hold", 32'(q), 32'(e.q));
        check_eq("r_hold", 32'(r), 32'(e.r));
    endtask

    initial begin
        bit any_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check_eq("rst_q", 32'(q), 0);
        check_eq("rst_r", 32'(r), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_dz", 32'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        run_div(4'd10, 4'd2, 1'b0);
        run_div(4'd15, 4'd2, 1'b0);
        run_div(4'd5, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("dz_held", 32'(div_zero), 1);
        run_div(4'd3, 4'd7, 1'b0);
        run_div(4'd15, 4'd1, 1'b1);
        run_div(4'd9, 4'd0, 1'b1);

        // Abort mid-CALC after a result with nonzero q and r.
        run_div(4'd15, 4'd2, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_q", 32'(q), 0);
        check_eq("abort_r", 32'(r), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_dz", 32'(div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) any_done = 1'b1;
        end
        check_eq("no_done_after_abort", 32'(any_done), 0);
        run_div(4'd9, 4'd4, 1'b0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_div(N'(i), N'(j), 1'b0);
            end
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
